// File: rtl/dwconv1d_sched_if.sv
// Handshake bundle between the job scheduler, its requesters and the shared
// depthwise engine.
interface dwconv1d_sched_if #(
    parameter int N_REQ = 3,
    parameter int CNT_W = 16
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic             eng_start;
    logic             eng_done;
    logic [N_REQ-1:0] rsp_done;
    logic [N_REQ-1:0] rsp_err;
    logic             busy;
    logic             err_sticky;
    logic [CNT_W-1:0] jobs_done;

    modport master (
        input  req, eng_done,
        output gnt, eng_start, rsp_done, rsp_err, busy, err_sticky, jobs_done
    );

    modport slave (
        output req, eng_done,
        input  gnt, eng_start, rsp_done, rsp_err, busy, err_sticky, jobs_done
    );
endinterface

// File: rtl/dwconv1d_sched.sv
// Round-robin scheduler sharing one depthwise conv engine among N_REQ
// requesters, with a done watchdog and a completed-job counter.
module dwconv1d_sched #(
    parameter int N_REQ   = 3,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    dwconv1d_sched_if.master bus
);
    localparam int               IDX_W      = $clog2(N_REQ);
    localparam logic [15:0]      TIMEOUT_C  = 16'(TIMEOUT);
    localparam logic [IDX_W:0]   N_REQ_C    = (IDX_W+1)'(N_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX_C = IDX_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE_OH_C   = {{(N_REQ-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LAUNCH   = 3'd1,
        S_RUN      = 3'd2,
        S_COMPLETE = 3'd3,
        S_ABORT    = 3'd4
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [IDX_W-1:0] ptr_r;
    logic [IDX_W-1:0] gnt_idx_r;
    logic [15:0]      wd_r;
    logic [N_REQ-1:0] gnt_r;
    logic             eng_start_r;
    logic [N_REQ-1:0] rsp_done_r;
    logic [N_REQ-1:0] rsp_err_r;
    logic             busy_r;
    logic             err_sticky_r;
    logic [CNT_W-1:0] jobs_done_r;

    logic [IDX_W:0]   pick_s;
    logic             pick_vld_s;
    logic [IDX_W-1:0] pick_idx_s;
    logic [N_REQ-1:0] pick_oh_s;

    // Returns {valid, index} of the first set request at or after p, wrapping.
    // Scanning downward lets the smallest offset from p overwrite the result last.
    function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDX_W-1:0] p);
        logic [IDX_W:0] res;
        logic [IDX_W:0] s;
        res = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            s = {1'b0, p} + (IDX_W+1)'(i);
            s = (s >= N_REQ_C) ? (s - N_REQ_C) : s;
            if (r[s[IDX_W-1:0]]) begin
                res = {1'b1, s[IDX_W-1:0]};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Round-robin arbitration over the live request vector.
    always_comb begin
        pick_s     = rr_pick(bus.req, ptr_r);
        pick_vld_s = pick_s[IDX_W];
        pick_idx_s = pick_s[IDX_W-1:0];
        pick_oh_s  = ONE_OH_C << pick_idx_s;
    end

    // Next-state logic; done wins over the watchdog on the same cycle.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (pick_vld_s) begin
                    state_next_s = S_LAUNCH;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_LAUNCH: state_next_s = S_RUN;
            S_RUN: begin
                if (bus.eng_done) begin
                    state_next_s = S_COMPLETE;
                end else if (wd_r == TIMEOUT_C) begin
                    state_next_s = S_ABORT;
                end else begin
                    state_next_s = S_RUN;
                end
            end
            S_COMPLETE: state_next_s = S_IDLE;
            S_ABORT:    state_next_s = S_IDLE;
            default:    state_next_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Grant, watchdog, pointer and all outputs, registered from the next state
    // so each pulse lines up with the state it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r        <= '0;
            gnt_idx_r    <= '0;
            wd_r         <= '0;
            gnt_r        <= '0;
            eng_start_r  <= 1'b0;
            rsp_done_r   <= '0;
            rsp_err_r    <= '0;
            busy_r       <= 1'b0;
            err_sticky_r <= 1'b0;
            jobs_done_r  <= '0;
        end else begin
            eng_start_r <= (state_next_s == S_LAUNCH);
            busy_r      <= (state_next_s != S_IDLE);
            rsp_done_r  <= (state_next_s == S_COMPLETE) ? gnt_r : '0;
            rsp_err_r   <= (state_next_s == S_ABORT) ? gnt_r : '0;
            case (state_r)
                S_IDLE: begin
                    gnt_r     <= pick_vld_s ? pick_oh_s : '0;
                    gnt_idx_r <= pick_idx_s;
                end
                S_LAUNCH: begin
                    wd_r <= '0;
                end
                S_RUN: begin
                    if (wd_r != TIMEOUT_C) begin
                        wd_r <= wd_r + 16'd1;
                    end
                    if (state_next_s == S_COMPLETE) begin
                        jobs_done_r <= jobs_done_r + CNT_ONE_C;
                    end
                    if (state_next_s == S_ABORT) begin
                        err_sticky_r <= 1'b1;
                    end
                end
                S_COMPLETE, S_ABORT: begin
                    gnt_r <= '0;
                    ptr_r <= (gnt_idx_r == LAST_IDX_C) ? '0 : (gnt_idx_r + 1'b1);
                end
                default: begin
                    gnt_r <= '0;
                end
            endcase
        end
    end

    assign bus.gnt        = gnt_r;
    assign bus.eng_start  = eng_start_r;
    assign bus.rsp_done   = rsp_done_r;
    assign bus.rsp_err    = rsp_err_r;
    assign bus.busy       = busy_r;
    assign bus.err_sticky = err_sticky_r;
    assign bus.jobs_done  = jobs_done_r;
endmodule

// File: tb/tb_dwconv1d_sched.sv
// Directed bench for dwconv1d_sched: engine done is driven by hand-timed
// stimulus and every expected value is worked out from the cycle timeline.
module tb_dwconv1d_sched;
    localparam int N  = 3;
    localparam int TO = 24;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   vec_cnt = 0;
    int   fail_cnt = 0;

    dwconv1d_sched_if #(.N_REQ(N), .CNT_W(CW)) bus ();

    dwconv1d_sched #(.N_REQ(N), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait: 0 = eng_start, 1 = any rsp_done, other = any rsp_err.
    task automatic wait_sig(input int which, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            case (which)
                0:       ok = (bus.eng_start === 1'b1);
                1:       ok = (|bus.rsp_done === 1'b1);
                default: ok = (|bus.rsp_err === 1'b1);
            endcase
        end
    endtask

    task automatic test_reset();
        logic [27:0] obs;
        rst_n = 1'b0;
        bus.req = 3'b000;
        bus.eng_done = 1'b0;
        repeat (3) tick();
        obs = {bus.gnt, bus.eng_start, bus.rsp_done, bus.rsp_err, bus.busy,
               bus.err_sticky, bus.jobs_done};
        vec_cnt++;
        if (obs !== 28'h0) begin
            fail_cnt++;
            $display("FAIL reset_outputs: got %h want %h", obs, 28'h0);
        end
        rst_n = 1'b1;
        repeat (2) tick();
        vec_cnt++;
        if ({bus.busy, bus.gnt, bus.eng_start} !== 5'b0) begin
            fail_cnt++;
            $display("FAIL reset_idle: got %b want %b", {bus.busy, bus.gnt, bus.eng_start}, 5'b0);
        end
    endtask

    task automatic test_single();
        int n_start;
        int n_done;
        n_start = 0;
        n_done = 0;
        bus.req = 3'b010;
        tick();
        vec_cnt++;
        if ({bus.eng_start, bus.gnt, bus.busy} !== 5'b1_010_1) begin
            fail_cnt++;
            $display("FAIL single_launch: got %b want %b", {bus.eng_start, bus.gnt, bus.busy}, 5'b1_010_1);
        end
        for (int i = 1; i < 20; i++) begin
            tick();
            n_start += int'(bus.eng_start);
            n_done += int'(|bus.rsp_done);
            if (i == 19) bus.eng_done = 1'b1;
        end
        vec_cnt++;
        if (n_start != 0 || n_done != 0) begin
            fail_cnt++;
            $display("FAIL single_run_quiet: got starts=%0d dones=%0d want 0 0", n_start, n_done);
        end
        tick();
        vec_cnt++;
        if ({bus.rsp_done, bus.gnt, bus.jobs_done} !== {3'b010, 3'b010, 16'd1}) begin
            fail_cnt++;
            $display("FAIL single_complete: got %h want %h", {bus.rsp_done, bus.gnt, bus.jobs_done},
                     {3'b010, 3'b010, 16'd1});
        end
        bus.req = 3'b000;
        bus.eng_done = 1'b0;
        tick();
        vec_cnt++;
        if ({bus.busy, bus.gnt, bus.rsp_done, bus.jobs_done} !== {1'b0, 3'b000, 3'b000, 16'd1}) begin
            fail_cnt++;
            $display("FAIL single_idle: got %h want %h", {bus.busy, bus.gnt, bus.rsp_done, bus.jobs_done},
                     {1'b0, 3'b000, 3'b000, 16'd1});
        end
    endtask

    task automatic test_contention();
        logic [2:0] exp;
        bit ok;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        bus.req = 3'b111;
        for (int j = 0; j < 6; j++) begin
            exp = 3'b001 << (j % 3);
            wait_sig(0, 6, ok);
            vec_cnt++;
            if (!ok || bus.gnt !== exp) begin
                fail_cnt++;
                $display("FAIL contention_gnt_%0d: got %b want %b (start seen %0d)", j, bus.gnt, exp, ok);
            end
            bus.req = 3'b111;
            tick();
            tick();
            bus.eng_done = 1'b1;
            wait_sig(1, 6, ok);
            vec_cnt++;
            if (!ok || bus.rsp_done !== exp) begin
                fail_cnt++;
                $display("FAIL contention_rsp_%0d: got %b want %b", j, bus.rsp_done, exp);
            end
            bus.req = bus.req & ~exp;
            bus.eng_done = 1'b0;
        end
        bus.req = 3'b000;
        tick();
        vec_cnt++;
        if ({bus.busy, bus.jobs_done} !== {1'b0, 16'd6}) begin
            fail_cnt++;
            $display("FAIL contention_count: got %h want %h", {bus.busy, bus.jobs_done}, {1'b0, 16'd6});
        end
    endtask

    task automatic test_stale_done();
        bit ok;
        bus.eng_done = 1'b1;
        bus.req = 3'b100;
        wait_sig(0, 4, ok);
        vec_cnt++;
        if (!ok || bus.gnt !== 3'b100) begin
            fail_cnt++;
            $display("FAIL stale_gnt: got %b want %b", bus.gnt, 3'b100);
        end
        tick();
        bus.eng_done = 1'b0;
        vec_cnt++;
        if ({bus.rsp_done, bus.busy} !== 4'b000_1) begin
            fail_cnt++;
            $display("FAIL stale_no_early: got %b want %b", {bus.rsp_done, bus.busy}, 4'b000_1);
        end
        tick();
        tick();
        vec_cnt++;
        if ({bus.rsp_done, bus.busy} !== 4'b000_1) begin
            fail_cnt++;
            $display("FAIL stale_still_run: got %b want %b", {bus.rsp_done, bus.busy}, 4'b000_1);
        end
        bus.eng_done = 1'b1;
        tick();
        vec_cnt++;
        if ({bus.rsp_done, bus.jobs_done} !== {3'b100, 16'd7}) begin
            fail_cnt++;
            $display("FAIL stale_complete: got %h want %h", {bus.rsp_done, bus.jobs_done}, {3'b100, 16'd7});
        end
        bus.req = 3'b000;
        bus.eng_done = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        bit ok;
        int n_bad;
        n_bad = 0;
        bus.req = 3'b010;
        wait_sig(0, 4, ok);
        vec_cnt++;
        if (!ok || bus.gnt !== 3'b010) begin
            fail_cnt++;
            $display("FAIL timeout_gnt: got %b want %b", bus.gnt, 3'b010);
        end
        for (int i = 1; i <= TO + 1; i++) begin
            tick();
            n_bad += int'(|bus.rsp_err) + int'(|bus.rsp_done);
        end
        vec_cnt++;
        if (n_bad != 0) begin
            fail_cnt++;
            $display("FAIL timeout_early: got %0d pulses want 0", n_bad);
        end
        tick();
        vec_cnt++;
        if ({bus.rsp_err, bus.rsp_done, bus.err_sticky, bus.jobs_done} !== {3'b010, 3'b000, 1'b1, 16'd7}) begin
            fail_cnt++;
            $display("FAIL timeout_abort: got %h want %h", {bus.rsp_err, bus.rsp_done, bus.err_sticky, bus.jobs_done},
                     {3'b010, 3'b000, 1'b1, 16'd7});
        end
        bus.req = 3'b000;
        tick();
        vec_cnt++;
        if ({bus.rsp_err, bus.busy, bus.err_sticky} !== 5'b000_0_1) begin
            fail_cnt++;
            $display("FAIL timeout_after: got %b want %b", {bus.rsp_err, bus.busy, bus.err_sticky}, 5'b000_0_1);
        end
        bus.req = 3'b100;
        wait_sig(0, 4, ok);
        vec_cnt++;
        if (!ok || bus.gnt !== 3'b100) begin
            fail_cnt++;
            $display("FAIL timeout_next_gnt: got %b want %b", bus.gnt, 3'b100);
        end
        tick();
        tick();
        bus.eng_done = 1'b1;
        wait_sig(1, 6, ok);
        vec_cnt++;
        if (!ok || {bus.rsp_done, bus.jobs_done, bus.err_sticky} !== {3'b100, 16'd8, 1'b1}) begin
            fail_cnt++;
            $display("FAIL timeout_next_done: got %h want %h", {bus.rsp_done, bus.jobs_done, bus.err_sticky},
                     {3'b100, 16'd8, 1'b1});
        end
        bus.req = 3'b000;
        bus.eng_done = 1'b0;
        tick();
    endtask

    task automatic test_tie();
        bit ok;
        bus.req = 3'b001;
        wait_sig(0, 4, ok);
        vec_cnt++;
        if (!ok || bus.gnt !== 3'b001) begin
            fail_cnt++;
            $display("FAIL tie_gnt: got %b want %b", bus.gnt, 3'b001);
        end
        repeat (TO + 1) tick();
        bus.eng_done = 1'b1;
        tick();
        vec_cnt++;
        if ({bus.rsp_done, bus.rsp_err, bus.jobs_done} !== {3'b001, 3'b000, 16'd9}) begin
            fail_cnt++;
            $display("FAIL tie_done_wins: got %h want %h", {bus.rsp_done, bus.rsp_err, bus.jobs_done},
                     {3'b001, 3'b000, 16'd9});
        end
        bus.req = 3'b000;
        bus.eng_done = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        logic [27:0] obs;
        bus.req = 3'b010;
        wait_sig(0, 4, ok);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        obs = {bus.gnt, bus.eng_start, bus.rsp_done, bus.rsp_err, bus.busy,
               bus.err_sticky, bus.jobs_done};
        vec_cnt++;
        if (!ok || obs !== 28'h0) begin
            fail_cnt++;
            $display("FAIL midrun_async_clear: got %h want %h (start seen %0d)", obs, 28'h0, ok);
        end
        tick();
        rst_n = 1'b1;
        bus.req = 3'b101;
        tick();
        vec_cnt++;
        if ({bus.eng_start, bus.gnt, bus.jobs_done} !== {1'b1, 3'b001, 16'd0}) begin
            fail_cnt++;
            $display("FAIL midrun_ptr_zero: got %h want %h", {bus.eng_start, bus.gnt, bus.jobs_done},
                     {1'b1, 3'b001, 16'd0});
        end
        bus.req = 3'b000;
        tick();
        bus.eng_done = 1'b1;
        wait_sig(1, 6, ok);
        bus.eng_done = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL sim_watchdog: time limit reached, got no finish want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_stale_done();
        test_timeout();
        test_tie();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
        $finish;
    end
endmodule
